// File: rtl/keypoint_streamer.sv
// keypoint_streamer: after detection finishes, streams both keypoint layers
// to a 16-bit ready/valid sink. Each layer gets a header word carrying the
// layer id and its count. Each keypoint then goes out as a row word followed
// by a col word, read one at a time from the layer's keypoint memory.
module keypoint_streamer #(
    parameter int KP_DEPTH = 4096,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] kp1_count,
    input  logic [CNT_W-1:0] kp2_count,
    output logic             kp_rd_en,
    output logic             kp_rd_sel,
    output logic [CNT_W-1:0] kp_rd_addr,
    input  logic [18:0]      kp_rd_data,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, HDR, RD, WAIT, ROW, COL, DONE} state_t;

    // Counts carry one extra bit so that a full memory (KP_DEPTH words) fits.
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(KP_DEPTH);

    state_t           state, state_nxt;
    logic [CNT_W:0]   cnt1, cnt2, cur_cnt;
    logic [CNT_W-1:0] index;
    logic [CNT_W:0]   index_inc;
    logic             layer;
    logic [18:0]      hold;

    function automatic logic [CNT_W:0] clamp(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] w;
        w = {1'b0, c};
        return (w > DEPTH_C) ? DEPTH_C : w;
    endfunction

    assign cur_cnt   = layer ? cnt2 : cnt1;
    assign index_inc = {1'b0, index} + 1'b1;

    // Next state and Moore outputs; every output idles at zero.
    always_comb begin
        state_nxt  = state;
        out_valid  = 1'b0;
        out_data   = 16'h0000;
        kp_rd_en   = 1'b0;
        kp_rd_sel  = 1'b0;
        kp_rd_addr = '0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = HDR;
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = 16'hA000 | {3'b000, layer, 12'h000} | (16'(cur_cnt) & 16'h0FFF);
                if (out_ready) begin
                    if (cur_cnt != '0) state_nxt = RD;
                    else if (!layer)   state_nxt = HDR;
                    else               state_nxt = DONE;
                end
            end
            RD: begin
                kp_rd_en   = 1'b1;
                kp_rd_sel  = layer;
                kp_rd_addr = index;
                state_nxt  = WAIT;
            end
            WAIT: begin
                state_nxt = ROW;
            end
            ROW: begin
                out_valid = 1'b1;
                out_data  = {7'b0, hold[18:10]};
                if (out_ready) state_nxt = COL;
            end
            COL: begin
                out_valid = 1'b1;
                out_data  = {6'b0, hold[9:0]};
                if (out_ready) begin
                    if (index_inc < cur_cnt) state_nxt = RD;
                    else if (!layer)         state_nxt = HDR;
                    else                     state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and datapath (latched counts, layer, index, read holding register).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt1  <= '0;
            cnt2  <= '0;
            index <= '0;
            layer <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt1  <= clamp(kp1_count);
                        cnt2  <= clamp(kp2_count);
                        layer <= 1'b0;
                        index <= '0;
                    end
                end
                HDR: begin
                    // An empty layer 1 falls straight through to the layer 2 header.
                    if (out_ready && cur_cnt == '0 && !layer) layer <= 1'b1;
                end
                WAIT: begin
                    hold <= kp_rd_data;
                end
                COL: begin
                    if (out_ready) begin
                        if (index_inc < cur_cnt) begin
                            index <= index_inc[CNT_W-1:0];
                        end else if (!layer) begin
                            layer <= 1'b1;
                            index <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keypoint_streamer.sv
// tb_keypoint_streamer: scoreboard bench. Expected words and read addresses are
// queued when a run is set up. A negedge monitor pops and compares them as the
// DUT transfers words and issues reads.
module tb_keypoint_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] kp1_count = '0;
    logic [11:0] kp2_count = '0;
    logic        kp_rd_en, kp_rd_sel;
    logic [11:0] kp_rd_addr;
    logic [18:0] kp_rd_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b1;
    logic        busy, done;

    keypoint_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .kp1_count(kp1_count), .kp2_count(kp2_count),
        .kp_rd_en(kp_rd_en), .kp_rd_sel(kp_rd_sel), .kp_rd_addr(kp_rd_addr),
        .kp_rd_data(kp_rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [18:0] mem1 [4096];
    logic [18:0] mem2 [4096];
    logic [15:0] wq [$];
    logic [12:0] rq [$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, last_x = 0, ha_cyc = 0, hb_cyc = 0;
    int n_done = 0, n_words = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // Keypoint memories: one-cycle registered read
    initial forever begin
        @(posedge clk);
        if (kp_rd_en) kp_rd_data <= kp_rd_sel ? mem2[kp_rd_addr] : mem1[kp_rd_addr];
    end

    // Downstream ready generator
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: scoreboard pops, stall stability, read order, done timing
    initial begin
        logic        prev_stall;
        logic [15:0] prev_data, exp_w;
        logic [31:0] exp_r;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_vld", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(prev_data));
                end
                if (out_valid && out_ready) begin
                    exp_w = (wq.size() > 0) ? wq.pop_front() : 16'hDEAD;
                    if (out_data[15:13] == 3'b101) begin
                        if (out_data[12]) hb_cyc = cyc;
                        else              ha_cyc = cyc;
                    end
                    last_x = cyc;
                    n_words++;
                    chk("word", 32'(out_data), 32'(exp_w));
                end
                if (kp_rd_en) begin
                    exp_r = (rq.size() > 0) ? 32'(rq.pop_front()) : 32'hFFFF_FFFF;
                    chk("rd_addr", 32'({kp_rd_sel, kp_rd_addr}), exp_r);
                end
                if (done) begin
                    n_done++;
                    chk("done_lat", 32'(cyc - last_x), 32'd1);
                    chk("busy_done", 32'(busy), 32'd1);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic push_t1();
        wq.push_back(16'hA002); wq.push_back(16'h0005); wq.push_back(16'h0007);
        wq.push_back(16'h01DF); wq.push_back(16'h027F);
        wq.push_back(16'hB001); wq.push_back(16'h0001); wq.push_back(16'h0002);
        rq.push_back(13'h0000); rq.push_back(13'h0001); rq.push_back(13'h1000);
    endtask

    task automatic load_exp(input int c1, input int c2);
        wq.push_back(16'hA000 | 16'(c1));
        for (int i = 0; i < c1; i++) begin
            wq.push_back({7'b0, mem1[i][18:10]});
            wq.push_back({6'b0, mem1[i][9:0]});
            rq.push_back({1'b0, 12'(i)});
        end
        wq.push_back(16'hB000 | 16'(c2));
        for (int i = 0; i < c2; i++) begin
            wq.push_back({7'b0, mem2[i][18:10]});
            wq.push_back({6'b0, mem2[i][9:0]});
            rq.push_back({1'b1, 12'(i)});
        end
    endtask

    task automatic pulse_start(input int c1, input int c2);
        @(posedge clk); #1;
        kp1_count = 12'(c1);
        kp2_count = 12'(c2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int d0, k;
        d0 = n_done;
        k  = 0;
        while (n_done == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_seen", 32'(n_done - d0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("wq_left", 32'(wq.size()), 32'd0);
        chk("rq_left", 32'(rq.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int w0, k;
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = 19'($urandom);
            mem2[i] = 19'($urandom);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_rd_en", 32'(kp_rd_en), 32'd0);
        chk("rst_rd_sel", 32'(kp_rd_sel), 32'd0);
        chk("rst_rd_addr", 32'(kp_rd_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Two layers, full-rate sink
        mem1[0] = {9'd5, 10'd7};
        mem1[1] = {9'd479, 10'd639};
        mem2[0] = {9'd1, 10'd2};
        push_t1();
        pulse_start(2, 1);
        wait_done(200);
        chk("t1_l1_time", 32'(hb_cyc - ha_cyc), 32'd9);

        // Both layers empty: headers only, no reads
        wq.push_back(16'hA000);
        wq.push_back(16'hB000);
        pulse_start(0, 0);
        wait_done(100);
        chk("empty_l1_time", 32'(hb_cyc - ha_cyc), 32'd1);

        // Same stream under random back-pressure
        ready_mode = 1;
        push_t1();
        pulse_start(2, 1);
        wait_done(2000);
        ready_mode = 0;

        // Second start mid-stream with changed counts is ignored
        load_exp(3, 2);
        pulse_start(3, 2);
        repeat (6) @(posedge clk);
        #1;
        kp1_count = 12'd7;
        kp2_count = 12'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(500);

        // Reset during a COL stall, then a clean replay
        push_t1();
        pulse_start(2, 1);
        w0 = n_words;
        k  = 0;
        while (n_words < w0 + 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        ready_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        chk("col_stall_vld", 32'(out_valid), 32'd1);
        chk("col_stall_data", 32'(out_data), 32'h0007);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        wq.delete();
        rq.delete();
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_drop", 32'(busy), 32'd0);
        push_t1();
        pulse_start(2, 1);
        wait_done(200);

        // Largest count: 4095 layer-1 keypoints
        load_exp(4095, 0);
        pulse_start(4095, 0);
        wait_done(20000);
        chk("big_l1_time", 32'(hb_cyc - ha_cyc), 32'd16381);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypoint_streamer.md
KEYPOINT_STREAMER -- requirements
Module: keypoint_streamer

Interface
- REQ-001: Parameter KP_DEPTH, default 4096; word depth of each keypoint memory.
- REQ-002: Parameter CNT_W, default 12; width of keypoint counts and read addresses.
- REQ-003: clk, input, 1; the single clock for the block.
- REQ-004: rst_n, input, 1; reset, synchronous and active-low.
- REQ-005: start, input, 1; one-cycle pulse, driven by detect_filter_done.
- REQ-006: kp1_count, input, CNT_W; number of valid layer-1 keypoints.
- REQ-007: kp2_count, input, CNT_W; number of valid layer-2 keypoints.
- REQ-008: kp_rd_en, output, 1; keypoint memory read strobe.
- REQ-009: kp_rd_sel, output, 1; memory select: 0 = keypoint_1_mem, 1 = keypoint_2_mem.
- REQ-010: kp_rd_addr, output, CNT_W; keypoint memory read address.
- REQ-011: kp_rd_data, input, 19; read data, [18:10] = row, [9:0] = col; valid exactly 1 cycle after kp_rd_en.
- REQ-012: out_valid, output, 1; out_data is valid.
- REQ-013: out_data, output, 16; stream word.
- REQ-014: out_ready, input, 1; downstream accepts the word; a transfer occurs on a clk edge with out_valid && out_ready.
- REQ-015: busy, output, 1; high from the cycle after an accepted start until done.
- REQ-016: done, output, 1; one-cycle completion pulse.

Function
- REQ-017: FSM states SHALL be IDLE, HDR, RD, WAIT, ROW, COL, DONE.
- REQ-018: In IDLE, start=1 SHALL latch both counts, clamp each to KP_DEPTH, set layer=0, index=0 and go to HDR; start SHALL be ignored in every other state.
- REQ-019: In HDR, out_data SHALL be 16'hA000 | (layer<<12) | count_of_layer[11:0] with out_valid=1.
- REQ-020: On the HDR transfer:
  - count_of_layer > 0 -> go to RD.
  - count_of_layer == 0 and layer=0 -> layer=1, stay in HDR.
  - count_of_layer == 0 and layer=1 -> go to DONE.
- REQ-021: RD SHALL assert kp_rd_en for exactly one cycle, with kp_rd_sel=layer and kp_rd_addr=index, then go to WAIT.
- REQ-022: WAIT SHALL register kp_rd_data into an internal 19-bit holding register, then go to ROW.
- REQ-023: ROW SHALL present out_data = {7'b0, row[8:0]}; on transfer go to COL.
- REQ-024: COL SHALL present out_data = {6'b0, col[9:0]}.
- REQ-025: On the COL transfer:
  - index+1 < count -> index+1, go to RD.
  - else if layer=0 -> layer=1, index=0, go to HDR.
  - else -> go to DONE.
- REQ-026: DONE SHALL assert done=1 for one cycle, keep busy=1 during that cycle, then return to IDLE.
- REQ-027: While out_valid=1 and out_ready=0, out_valid and out_data SHALL hold stable; state SHALL not advance.
- REQ-028: out_valid SHALL be 1 only in HDR, ROW and COL; kp_rd_en SHALL be 1 only in RD.
- REQ-029: Each keypoint SHALL cost 2 output words plus 2 non-output cycles (RD, WAIT); with out_ready held at 1, a layer of N keypoints takes 1 + 4N cycles.
- REQ-030: Keypoints SHALL be emitted in ascending address order; all of layer 1 SHALL precede all of layer 2.
- REQ-031: Latched counts SHALL not change if kp1_count or kp2_count change during busy.
- REQ-032: A count above KP_DEPTH SHALL be clamped to KP_DEPTH.

Reset
- REQ-033: rst_n=0 at a clk edge SHALL force, at any state including mid-stream:
  - state=IDLE, index=0, layer=0, holding register=0.
  - out_valid=0, out_data=0, kp_rd_en=0, kp_rd_sel=0, kp_rd_addr=0, busy=0, done=0.
- REQ-034: A start arriving in the same cycle as rst_n=0 SHALL be discarded.

Verification
- REQ-035: kp1_count=2 (mem1[0]=(5,7), mem1[1]=(479,639)), kp2_count=1 (mem2[0]=(1,2)), out_ready=1, start pulse -> expected stream:
  - A002, 0005, 0007, 01DF, 027F,
  - B001, 0001, 0002,
  - then done one cycle after the last transfer.
- REQ-036: kp1_count=0, kp2_count=0 -> stream A000, B000, then done; kp_rd_en never asserted.
- REQ-037: Scenario REQ-035 with out_ready toggled randomly -> identical word sequence, with out_data stable throughout every stall.
- REQ-038: Second start pulse mid-stream, with kp1_count changed -> ignored; output stream unchanged.
- REQ-039: rst_n=0 during a COL stall -> next cycle out_valid=0, busy=0; a fresh start replays the full stream from A00x.
- REQ-040: kp1_count=4095, out_ready=1 -> header AFFF, 8190 data words, addresses 0..4094, total layer-1 time 16381 cycles.
